// File: rtl/counter_step_debouncer_pkg.sv
// Shared types and default timing for the button step debouncer.
// FSM encodings, default constants and a small constant helper.
package counter_step_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_DELAY_DEF    = 64;
  localparam int REPEAT_PERIOD_DEF   = 8;
  localparam int REPEAT_EN_DEF       = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_step_debouncer_if.sv
// Button-side bundle between the board stimulus and the debouncer.
// master drives btn_in/en; slave drives step_pulse/btn_level/repeat_active.
interface counter_step_debouncer_if;
  import counter_step_debouncer_pkg::*;

  logic btn_in;
  logic en;
  logic step_pulse;
  logic btn_level;
  logic repeat_active;

  modport master (
    output btn_in, en,
    input  step_pulse, btn_level, repeat_active
  );

  modport slave (
    input  btn_in, en,
    output step_pulse, btn_level, repeat_active
  );

endinterface

// File: rtl/counter_step_debouncer_input_sync_debounce.sv
// Synchroniser + debounce counter for the raw button input.
// Ports: clk, rst, btn_i -> level_o, level_nxt_o (next level), rise_o.
module counter_step_debouncer_input_sync_debounce
  import counter_step_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic level_nxt_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; adopt new level on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign rise_o      = level_q & ~prev_q;

endmodule

// File: rtl/counter_step_debouncer.sv
// Button conditioner producing step strobes with hold-to-repeat.
// Ports: clk, rst (sync, active high), bus (slave: btn_in, en -> step_pulse, btn_level, repeat_active).
module counter_step_debouncer
  import counter_step_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int REPEAT_EN       = REPEAT_EN_DEF
) (
  input logic                     clk,
  input logic                     rst,
  counter_step_debouncer_if.slave bus
);

  localparam int TW =
    $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic REN = 1'(REPEAT_EN != 0);

  logic          level, level_nxt, rise;
  logic          go;
  logic          delay_hit, period_hit;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_q, pulse_d;
  logic          rep_q;

  counter_step_debouncer_input_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (bus.btn_in),
    .level_o    (level),
    .level_nxt_o(level_nxt),
    .rise_o     (rise)
  );

  // Using the next level lets a release on this edge win over a pulse.
  assign go         = level_nxt & bus.en;
  assign delay_hit  = (timer_q == TW'(REPEAT_DELAY - 1));
  assign period_hit = (timer_q == TW'(REPEAT_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      rep_q   <= (state_d == REPEAT);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    if (!go) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          timer_d = '0;
          if (rise) state_d = HOLD;
        end
        state_q == HOLD: begin
          if (REN && delay_hit) begin
            state_d = REPEAT;
            timer_d = '0;
          end
        end
        state_q == REPEAT: begin
          if (period_hit) timer_d = '0;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    pulse_d = 1'b0;
    if (go) begin
      unique case (1'b1)
        state_q == IDLE:   pulse_d = rise;
        state_q == HOLD:   pulse_d = REN & delay_hit;
        state_q == REPEAT: pulse_d = period_hit;
        default:           pulse_d = 1'b0;
      endcase
    end
  end

  assign bus.step_pulse    = pulse_q;
  assign bus.btn_level     = level;
  assign bus.repeat_active = rep_q;

endmodule

// File: tb/tb_counter_step_debouncer.sv
// Directed bench for counter_step_debouncer with a timing-rule model.
// Two DUTs share stimulus: auto-repeat on (u1) and off (u2).
module tb_counter_step_debouncer;

  localparam int SYNC = 2;
  localparam int DB   = 16;
  localparam int DLY  = 64;
  localparam int PER  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  counter_step_debouncer_if b1 ();
  counter_step_debouncer_if b2 ();

  assign b1.btn_in = btn;
  assign b1.en     = en;
  assign b2.btn_in = btn;
  assign b2.en     = en;

  counter_step_debouncer u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  counter_step_debouncer #(.REPEAT_EN(0)) u2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
  );

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

  // Model state: delayed button history, debounced level, press start edge.
  bit hist[$];
  bit m_valid = 1'b0;
  bit m_lvl, m_lvl_prev;
  int m_run;
  int m_press[2];
  bit m_pulse[2];
  bit m_rep[2];

  always @(posedge clk) begin
    bit s, l0, lp, rise, keep;
    int d, ren;
    ecnt++;
    if (rst) begin
      hist.delete();
      m_lvl = 0; m_lvl_prev = 0; m_run = 0;
      for (int k = 0; k < 2; k++) begin
        m_press[k] = -1; m_pulse[k] = 0; m_rep[k] = 0;
      end
      m_valid = 1'b1;
    end else begin
      s = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
      hist.push_front(btn);
      if (hist.size() > SYNC) void'(hist.pop_back());
      l0 = m_lvl;
      lp = m_lvl_prev;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_lvl_prev = l0;
      rise = l0 && !lp;
      keep = m_lvl && en;
      for (int k = 0; k < 2; k++) begin
        ren = (k == 0) ? 1 : 0;
        m_pulse[k] = 0;
        if (!keep) begin
          m_press[k] = -1;
        end else if (m_press[k] < 0) begin
          if (rise) begin
            m_press[k] = ecnt;
            m_pulse[k] = 1;
          end
        end else begin
          d = ecnt - m_press[k];
          m_pulse[k] = (ren == 1) &&
            (d == DLY || (d > DLY && (d - DLY) % PER == 0));
        end
        m_rep[k] = (m_press[k] >= 0) && (ren == 1) &&
                   (ecnt - m_press[k] >= DLY);
      end
    end
  end

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge %0d: got %b expected %b",
               nm, ecnt, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int p1[$], p2[$], lr[$], rr1[$], rr2[$];
  logic last_l = 1'b0, last_r1 = 1'b0, last_r2 = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pulse_u1", b1.step_pulse, m_pulse[0]);
      chk("level_u1", b1.btn_level, m_lvl);
      chk("repeat_u1", b1.repeat_active, m_rep[0]);
      chk("pulse_u2", b2.step_pulse, m_pulse[1]);
      chk("level_u2", b2.btn_level, m_lvl);
      chk("repeat_u2", b2.repeat_active, m_rep[1]);
      if (b1.step_pulse === 1'b1) p1.push_back(ecnt);
      if (b2.step_pulse === 1'b1) p2.push_back(ecnt);
      if (b1.btn_level === 1'b1 && !last_l) lr.push_back(ecnt);
      if (b1.repeat_active === 1'b1 && !last_r1)
        rr1.push_back(ecnt);
      if (b2.repeat_active === 1'b1 && !last_r2)
        rr2.push_back(ecnt);
      last_l  = (b1.btn_level === 1'b1);
      last_r1 = (b1.repeat_active === 1'b1);
      last_r2 = (b2.repeat_active === 1'b1);
    end
  end

  function automatic int first_at(input int q[$], input int s);
    foreach (q[i]) if (q[i] >= s) return q[i];
    return -1;
  endfunction

  function automatic int count_in(input int q[$], input int a,
                                  input int b);
    int n = 0;
    foreach (q[i]) if (q[i] >= a && q[i] <= b) n++;
    return n;
  endfunction

  function automatic int rel(input int e, input int s);
    return (e < 0) ? -1 : e - s + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(5);

    // Clean press held 5 cycles past debounce
    s = ecnt + 1;
    btn = 1'b1;
    tick(23);
    btn = 1'b0;
    tick(60);
    chk_int("clean_level_edge", rel(first_at(lr, s), s), 18);
    chk_int("clean_pulse_edge", rel(first_at(p1, s), s), 19);
    chk_int("clean_pulses_u1", count_in(p1, s, ecnt), 1);
    chk_int("clean_pulses_u2", count_in(p2, s, ecnt), 1);

    // Bounce shorter than debounce window
    s = ecnt + 1;
    for (int i = 0; i < 40; i++) begin
      btn = ((i / 3) % 2 == 0);
      tick(1);
    end
    btn = 1'b0;
    tick(30);
    chk_int("bounce_pulses", count_in(p1, s, ecnt), 0);
    chk_int("bounce_level", count_in(lr, s, ecnt), 0);

    // Long hold with auto-repeat
    s = ecnt + 1;
    btn = 1'b1;
    tick(200);
    btn = 1'b0;
    tick(40);
    chk_int("hold_p1", rel(first_at(p1, s), s), 19);
    chk_int("hold_p2", rel(first_at(p1, s + 19), s), 83);
    chk_int("hold_p3", rel(first_at(p1, s + 83), s), 91);
    chk_int("hold_count_u1", count_in(p1, s, ecnt), 18);
    chk_int("hold_count_u2", count_in(p2, s, ecnt), 1);
    chk_int("hold_rep_edge", rel(first_at(rr1, s), s), 83);
    chk_int("hold_rep_u2", count_in(rr2, s, ecnt), 0);

    // Enable low during press, raised while held
    s = ecnt + 1;
    en = 1'b0;
    btn = 1'b1;
    tick(30);
    en = 1'b1;
    tick(30);
    btn = 1'b0;
    tick(40);
    chk_int("en_pulses", count_in(p1, s, ecnt), 0);
    s = ecnt + 1;
    btn = 1'b1;
    tick(25);
    btn = 1'b0;
    tick(40);
    chk_int("en_repress", rel(first_at(p1, s), s), 19);

    // Reset pulse in the middle of a hold
    s = ecnt + 1;
    btn = 1'b1;
    tick(49);
    rst = 1'b1;
    tick(1);
    chk("rst_pulse", b1.step_pulse, 1'b0);
    chk("rst_level", b1.btn_level, 1'b0);
    chk("rst_repeat", b1.repeat_active, 1'b0);
    rst = 1'b0;
    tick(70);
    btn = 1'b0;
    tick(50);
    chk_int("rst_first", rel(first_at(p1, s), s), 19);
    chk_int("rst_fresh", rel(first_at(p1, s + 50), s), 69);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
